mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters: none.
REQ-002 Clock, reset and ports SHALL be exactly as below; one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous reset, active-high
- memValid  in  1  MEM stage holds a valid instruction
- loadSignal  in  1  instruction is a load
- storeSignal  in  1  instruction is a store
- loadStoreByteSelect  in  3  funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- memAddr  in  32  effective address (ALU result)
- storeData  in  32  unaligned store operand
- stallReq  out  1  freeze IF..MEM pipeline registers
- busReq  out  1  data-bus request
- busWe  out  1  1 = write
- busAddr  out  32  word-aligned address ({addr[31:2],2'b00})
- busBe  out  4  byte enables
- busWdata  out  32  lane-replicated write data
- busGnt  in  1  request accepted this cycle
- busRvalid  in  1  read data valid this cycle
- busRdata  in  32  read word
- loadData  out  32  aligned, extended load result
- loadDataValid  out  1  loadData valid, one-cycle pulse
- misalignTrap  out  1  misaligned-access pulse

Function
REQ-003 FSM states SHALL be IDLE, REQ, RESP, DONE.
REQ-004 IDLE: when memValid && (loadSignal || storeSignal), the block SHALL capture addr, funct3, busWe, busBe and busWdata into registers, assert stallReq combinationally, and move to REQ. Otherwise stallReq=0.
REQ-005 REQ: busReq=1 with registered fields stable, and stallReq=1. On busGnt, a store SHALL move to DONE and a load SHALL move to RESP.
REQ-006 RESP: busReq=0 and stallReq=1. On busRvalid, the block SHALL register the aligned and extended busRdata into loadData and move to DONE.
REQ-007 DONE: stallReq=0, and loadDataValid=1 only for loads. The block SHALL ignore memValid for this cycle and always return to IDLE.
REQ-008 Latency with zero-wait bus: a load SHALL stall 3 cycles, a store SHALL stall 2 cycles. Each bus wait cycle SHALL add one stall cycle.
REQ-009 Byte enables:
- B: 4'b0001<<addr[1:0]
- H: 4'b0011<<addr[1:0], truncated to 4 bits
- W: 4'b1111
REQ-010 Write data replication:
- B: {4{storeData[7:0]}}
- H: {2{storeData[15:0]}}
- W: storeData
REQ-011 Load data: the addressed lane SHALL be shifted down by addr[1:0]*8. LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, LW SHALL pass through.
REQ-012 A busRvalid outside RESP, or a busGnt outside REQ, SHALL be ignored.
REQ-013 busReq SHALL NOT drop in REQ before busGnt.

Reset
REQ-014 rst SHALL force IDLE and clear all output registers, including mid-transaction. All outputs SHALL be 0 in the cycle after rst: busReq, busWe, busAddr, busBe, busWdata, loadData, loadDataValid, misalignTrap, stallReq (stallReq while memValid=0).
REQ-015 The first access after reset SHALL be accepted normally from IDLE.

Configuration
REQ-016 Macro MISALIGN_TRAP_EN.
- Defined: in IDLE, H with addr[0]=1 or W with addr[1:0]!=0 SHALL go directly to DONE with busReq never asserted and misalignTrap=1 in DONE (one cycle), stalling 1 cycle.
- Undefined: misalignTrap SHALL be tied 0 and the access SHALL be issued with truncated enables per REQ-009.

Structure
REQ-017 The memCtrlStateType enum SHALL be added to loopyV_data_types. Funct3 constants (FUNCT3_BYTE etc.) SHALL be reused from that package.
REQ-018 Lane and extend logic SHALL live in a combinational sub-module mem_align (enables, write replication, load extraction). The FSM and registers SHALL stay in mem_access_ctrl.

Verification
REQ-019 SW addr 0x100, data 0xDEADBEEF, busGnt immediate -> busBe=1111, busWdata=0xDEADBEEF, stallReq high 2 cycles, then DONE.
REQ-020 LB addr 0x203, busRdata 0x80FFFFFF, gnt and rvalid each after 2 wait cycles -> loadData=0xFFFFFF80, loadDataValid one pulse, stall 7 cycles.
REQ-021 LHU addr 0x102, busRdata 0xBEEF1234 -> busBe=1100, loadData=0x0000BEEF; SB addr 0x101, data 0xAB -> busBe=0010, busWdata=0xABABABAB.
REQ-022 rst asserted in RESP -> next cycle IDLE, busReq=0, stallReq=0; a late busRvalid produces no loadDataValid.
REQ-023 LW addr 0x102: with MISALIGN_TRAP_EN -> no busReq, misalignTrap pulse, 1 stall cycle; without it -> busBe=1111, no trap.

Source files
------------

// File: rtl/loopyV_data_types.sv
// loopyV_data_types: shared core types, funct3 encodings and the memory-controller state enum
package loopyV_data_types;
    localparam logic [2:0] FUNCT3_BYTE   = 3'b000;
    localparam logic [2:0] FUNCT3_HALF   = 3'b001;
    localparam logic [2:0] FUNCT3_WORD   = 3'b010;
    localparam logic [2:0] FUNCT3_BYTE_U = 3'b100;
    localparam logic [2:0] FUNCT3_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } memCtrlStateType;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        return (funct3[1:0] == 2'b01 && off[0]) || (funct3 == FUNCT3_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: byte-lane enables and store replication for the issuing access,
// lane extraction and sign/zero extension for the returning load word
module mem_align
    import loopyV_data_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);
    logic        is_b, is_h;
    logic [15:0] ld_h;

    assign is_b  = funct3 == FUNCT3_BYTE || funct3 == FUNCT3_BYTE_U;
    assign is_h  = funct3 == FUNCT3_HALF || funct3 == FUNCT3_HALF_U;
    assign be    = is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
    assign wdata = is_b ? {4{store_data[7:0]}} : is_h ? {2{store_data[15:0]}} : store_data;
    assign ld_h  = 16'(rdata >> {ld_off, 3'b000});
    assign ldata = ld_funct3 == FUNCT3_BYTE   ? {{24{ld_h[7]}}, ld_h[7:0]} :
                   ld_funct3 == FUNCT3_BYTE_U ? {24'b0, ld_h[7:0]} :
                   ld_funct3 == FUNCT3_HALF   ? {{16{ld_h[15]}}, ld_h} :
                   ld_funct3 == FUNCT3_HALF_U ? {16'b0, ld_h} : rdata;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store bus sequencer with pipeline stall.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses trap instead of issuing.
module mem_access_ctrl
    import loopyV_data_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        memValid,
    input  logic        loadSignal,
    input  logic        storeSignal,
    input  logic [2:0]  loadStoreByteSelect,
    input  logic [31:0] memAddr,
    input  logic [31:0] storeData,
    output logic        stallReq,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [3:0]  busBe,
    output logic [31:0] busWdata,
    input  logic        busGnt,
    input  logic        busRvalid,
    input  logic [31:0] busRdata,
    output logic [31:0] loadData,
    output logic        loadDataValid,
    output logic        misalignTrap
);
    memCtrlStateType state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d, wdata_n, ldata_n;
    logic [3:0]  be_q, be_d, be_n;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d, trap_q, trap_d, misalign;

    mem_align u_align (
        .funct3    (loadStoreByteSelect),
        .off       (memAddr[1:0]),
        .store_data(storeData),
        .ld_funct3 (funct3_q),
        .ld_off    (addr_q[1:0]),
        .rdata     (busRdata),
        .be        (be_n),
        .wdata     (wdata_n),
        .ldata     (ldata_n)
    );

`ifdef MISALIGN_TRAP_EN
    assign misalign     = is_misaligned(loadStoreByteSelect, memAddr[1:0]);
    assign misalignTrap = state_q == DONE && trap_q;
`else
    assign misalign     = 1'b0;
    assign misalignTrap = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        ldata_d  = ldata_q;
        trap_d   = trap_q;
        stallReq = 1'b0;
        case (state_q)
            IDLE: if (memValid && (loadSignal || storeSignal)) begin
                stallReq = 1'b1;
                addr_d   = memAddr;
                funct3_d = loadStoreByteSelect;
                we_d     = storeSignal;
                be_d     = be_n;
                wdata_d  = wdata_n;
                trap_d   = misalign;
                state_d  = misalign ? DONE : REQ;
            end
            REQ: begin
                stallReq = 1'b1;
                if (busGnt) state_d = we_q ? DONE : RESP;
            end
            RESP: begin
                stallReq = 1'b1;
                if (busRvalid) begin
                    ldata_d = ldata_n;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            ldata_q  <= '0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            ldata_q  <= ldata_d;
            trap_q   <= trap_d;
        end
    end

    assign busReq        = state_q == REQ;
    assign busWe         = we_q;
    assign busAddr       = {addr_q[31:2], 2'b00};
    assign busBe         = be_q;
    assign busWdata      = wdata_q;
    assign loadData      = ldata_q;
    assign loadDataValid = state_q == DONE && !we_q && !trap_q;
endmodule
